fetch_unit: RTL and testbench

Instruction fetch stage upstream of the decode-side instruction queue. Generates sequential 32-bit PCs, issues read requests to instruction memory, matches returning words to their PCs, and presents {pc, instr} pairs downstream over valid/ready. A credit scheme bounds in-flight plus buffered fetches, so the unbackpressured memory response is always accepted. An epoch bit discards fetches made stale by a redirect.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 50 +++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and queue entry types for the fetch stage.
//   XLEN         architectural address/data width
//   INSTR_BYTES  bytes per instruction (PC increment)
//   pend_entry_t {epoch, pc} of an issued, not yet returned fetch
//   rsp_entry_t  {epoch, pc, instr} of a returned fetch awaiting decode
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic            epoch;
    logic [XLEN-1:0] pc;
  } pend_entry_t;

  typedef struct packed {
    logic            epoch;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } rsp_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: single-read single-write circular queue of entry_t.
//   clk_i, rst_ni  clock, asynchronous active-low reset (pointers only)
//   push_i/data_i  write data_i at the tail
//   pop_i          advance the head
//   data_o         current head entry (combinational read)
//   full_o/empty_o occupancy; the last-op bit tells full from empty
//                  when the pointers are equal
module fetch_queue #(
  parameter int unsigned DepthLog2 = 2,
  parameter type         entry_t   = logic [31:0]
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned Depth = 2 ** DepthLog2;

  logic [DepthLog2-1:0] wptr_q;
  logic [DepthLog2-1:0] rptr_q;
  logic                 last_push_q;
  entry_t               mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      last_push_q <= 1'b0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      // Occupancy only changes direction when exactly one side moves.
      if (push_i != pop_i) last_push_q <= push_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (wptr_q == rptr_q) &&  last_push_q;
  assign empty_o = (wptr_q == rptr_q) && !last_push_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with credit-bounded
// outstanding requests and epoch-based squashing on redirect.
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   imem_req_valid_o/addr_o/ready_i   fetch request to instruction memory
//   imem_rsp_valid_i/data_i       in-order read data, never backpressured
//   redirect_valid_i/pc_i         one-cycle pulse restarting fetch
//   inst_valid_o/pc_o/data_o/ready_i  {pc, instr} towards decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] ResetPc = '0,
  parameter int unsigned     OutLog2 = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [XLEN-1:0] inst_data_o,
  input  logic            inst_ready_i
);

  localparam int unsigned Depth = 2 ** OutLog2;
  localparam int unsigned CRW   = OutLog2 + 1;  // credit register width
  localparam int unsigned CW    = OutLog2 + 2;  // headroom for +2 returns
  localparam logic [XLEN-1:0] AlignMask = XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] pc_q;
  logic            epoch_q;
  logic [CRW-1:0]  credit_q;

  pend_entry_t pend_wdata, pend_head;
  logic        pend_full, pend_empty, pend_pop;
  rsp_entry_t  rsp_wdata, rsp_head;
  logic        rsp_full, rsp_empty, rsp_pop;

  logic           issue, rsp_keep, rsp_drop, head_stale, out_fire;
  logic [CW-1:0]  credit_sum;
  logic [CRW-1:0] credit_nxt;

  // Gated by rst_ni so no request is offered while reset is held, even
  // though the credit counter already sits at Depth.
  assign imem_req_valid_o = rst_ni && (credit_q != '0);
  assign imem_req_addr_o  = pc_q;

  assign inst_valid_o = !rsp_empty && (rsp_head.epoch == epoch_q);
  assign inst_pc_o    = rsp_head.pc;
  assign inst_data_o  = rsp_head.instr;

  always_comb begin
    issue      = imem_req_valid_o && imem_req_ready_i;
    pend_wdata = '{epoch: epoch_q, pc: pc_q};
    pend_pop   = imem_rsp_valid_i && !pend_empty;
    rsp_keep   = pend_pop && (pend_head.epoch == epoch_q);
    rsp_drop   = pend_pop && !rsp_keep;
    rsp_wdata  = '{epoch: pend_head.epoch, pc: pend_head.pc, instr: imem_rsp_data_i};
    head_stale = !rsp_empty && (rsp_head.epoch != epoch_q);
    out_fire   = inst_valid_o && inst_ready_i;
    // A stale head and an output pop are mutually exclusive, so each
    // response-queue pop returns exactly one credit.
    rsp_pop    = head_stale || out_fire;
    credit_sum = CW'(credit_q) + CW'(rsp_drop) + CW'(rsp_pop) - CW'(issue);
    credit_nxt = (credit_sum > CW'(Depth)) ? CRW'(Depth) : credit_sum[CRW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= ResetPc;
      epoch_q  <= 1'b0;
      credit_q <= CRW'(Depth);
    end else begin
      credit_q <= credit_nxt;
      if (redirect_valid_i) begin
        pc_q    <= redirect_pc_i & ~AlignMask;
        epoch_q <= ~epoch_q;
      end else if (issue) begin
        pc_q <= pc_q + XLEN'(INSTR_BYTES);
      end
    end
  end

  fetch_queue #(
    .DepthLog2(OutLog2),
    .entry_t  (pend_entry_t)
  ) u_pend_q (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (issue),
    .data_i (pend_wdata),
    .pop_i  (pend_pop),
    .data_o (pend_head),
    .full_o (pend_full),
    .empty_o(pend_empty)
  );

  fetch_queue #(
    .DepthLog2(OutLog2),
    .entry_t  (rsp_entry_t)
  ) u_rsp_q (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (rsp_keep),
    .data_i (rsp_wdata),
    .pop_i  (rsp_pop),
    .data_o (rsp_head),
    .full_o (rsp_full),
    .empty_o(rsp_empty)
  );

  a_rsp_has_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> !pend_empty);
  a_pend_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    issue |-> !pend_full);
  a_rsp_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_keep |-> !rsp_full);
  a_credit_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_q <= CRW'(Depth));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, redir_valid;
  logic [31:0] req_addr, rsp_data, redir_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_pc, inst_data;

  logic        w_req_valid, w_inst_valid;
  logic [31:0] w_req_addr, w_inst_pc, w_inst_data;
  logic        w_req_ready = 1'b1, w_rsp_valid = 1'b0, w_redir_valid = 1'b0, w_inst_ready = 1'b1;
  logic [31:0] w_rsp_data = '0, w_redir_pc = '0;

  always #5 clk = ~clk;

  fetch_unit #(.ResetPc(32'h0000_0100), .OutLog2(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_valid_o(req_valid), .imem_req_addr_o(req_addr), .imem_req_ready_i(req_ready),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .redirect_valid_i(redir_valid), .redirect_pc_i(redir_pc),
    .inst_valid_o(inst_valid), .inst_pc_o(inst_pc), .inst_data_o(inst_data),
    .inst_ready_i(inst_ready)
  );

  fetch_unit #(.ResetPc(32'hFFFF_FFFC), .OutLog2(2)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_valid_o(w_req_valid), .imem_req_addr_o(w_req_addr), .imem_req_ready_i(w_req_ready),
    .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
    .redirect_valid_i(w_redir_valid), .redirect_pc_i(w_redir_pc),
    .inst_valid_o(w_inst_valid), .inst_pc_o(w_inst_pc), .inst_data_o(w_inst_data),
    .inst_ready_i(w_inst_ready)
  );

  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  typedef struct { int ep; logic [31:0] pc; logic [31:0] data; } exp_t;

  mem_req_t memq[$];
  exp_t     sb[$];

  int n_checks = 0, n_err = 0;
  int cyc = 0, last_due = 0, last_redir_cyc = -100;
  int lat_min = 1, lat_max = 1;
  bit req_rand = 0, req_fix = 1, inst_rand = 0, inst_fix = 1, redir_rand = 0;
  bit redir_req = 0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] exp_pc = 32'h0000_0100;
  int tb_ep = 0;

  logic        s_req_v, s_inst_v;
  logic [31:0] s_req_a, s_inst_pc, s_inst_d;
  int n_issued = 0, first_valid_cyc = 0, n_valid = 0;
  bit cap_en = 0, watch = 0, seen40 = 0;
  logic [31:0] cap_addr = '0, first_pc = '0, first_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample outputs, choose inputs, update memory/scoreboard models.
  task automatic drive();
    int lat, due;
    cyc++;
    s_req_v = req_valid;   s_req_a   = req_addr;
    s_inst_v = inst_valid; s_inst_pc = inst_pc; s_inst_d = inst_data;

    req_ready  = req_rand  ? 1'($urandom_range(0, 1)) : req_fix;
    inst_ready = inst_rand ? 1'($urandom_range(0, 1)) : inst_fix;
    if (redir_rand && (cyc - last_redir_cyc >= 16) && $urandom_range(0, 15) == 0) begin
      redir_req = 1'b1;
      redir_tgt = $urandom;
    end
    redir_valid = redir_req;
    redir_pc    = redir_tgt;

    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end

    if (s_req_v && req_ready) begin
      chk("req_addr", s_req_a, exp_pc);
      lat = $urandom_range(lat_min, lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: s_req_a, due: due});
      sb.push_back('{ep: tb_ep, pc: exp_pc, data: mem_word(exp_pc)});
      exp_pc += 32'd4;
      n_issued++;
      if (cap_en) begin cap_addr = s_req_a; cap_en = 0; end
    end

    if (s_inst_v) begin
      if (first_valid_cyc == 0) first_valid_cyc = cyc;
      if (watch) begin first_pc = s_inst_pc; watch = 0; end
      if (s_inst_pc == 32'h40) seen40 = 1;
      while (sb.size() > 0 && sb[0].ep != tb_ep) void'(sb.pop_front());
      if (sb.size() == 0) chk("out_valid_no_entry", {31'b0, s_inst_v}, 32'd0);
      else begin
        chk("out_pc", s_inst_pc, sb[0].pc);
        chk("out_data", s_inst_d, sb[0].data);
        if (inst_ready) void'(sb.pop_front());
      end
    end

    chk("credit_range", {31'b0, dut.credit_q <= 3'd4}, 32'd1);

    if (redir_req) begin
      exp_pc = redir_tgt & ~32'h3;
      tb_ep++;
      watch = 1;
      redir_req = 1'b0;
      last_redir_cyc = cyc;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive();
    end
  endtask

  task automatic drain_check(input string tag);
    req_rand = 0; inst_rand = 0; redir_rand = 0;
    req_fix = 0; inst_fix = 1;
    step(16);
    chk({tag, "_credit_idle"}, {29'b0, dut.credit_q}, 32'd4);
    while (sb.size() > 0 && sb[0].ep != tb_ep) void'(sb.pop_front());
    chk({tag, "_sb_drained"}, sb.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_ready = 1'b0; inst_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    redir_valid = 1'b0; redir_pc = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_addr", req_addr, 32'h0000_0100);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_credit", {29'b0, dut.credit_q}, 32'd4);
    chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
    chk("rst_wrap_valid", {31'b0, w_req_valid}, 32'd0);

    // Sequential fetch, 1-cycle memory, downstream always ready.
    rst_n = 1'b1;
    #1;
    drive();
    chk("first_req_valid", {31'b0, s_req_v}, 32'd1);
    chk("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_second_addr", w_req_addr, 32'h0000_0000);
    drive();
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (s_inst_v) n_valid++;
    end
    chk("first_out_cycle", first_valid_cyc, 32'd3);
    chk("out_every_cycle", n_valid, 32'd10);
    drain_check("t1");

    // Downstream stalled: credits cap issues at Depth, then resume.
    req_fix = 1; inst_fix = 0; n_issued = 0; cap_en = 1;
    step(20);
    first_addr = cap_addr;
    chk("stall_issue_count", n_issued, 32'd4);
    chk("stall_req_valid_low", {31'b0, s_req_v}, 32'd0);
    inst_fix = 1; cap_en = 1;
    step(12);
    chk("resume_addr", cap_addr, first_addr + 32'd16);
    drain_check("t2");

    // Redirect with three fetches in flight.
    lat_min = 3; lat_max = 3; req_fix = 1; inst_fix = 1;
    step(2);
    redir_req = 1; redir_tgt = 32'h0000_2003;
    step(1);
    step(15);
    chk("redir_first_pc", first_pc, 32'h0000_2000);
    drain_check("t3");

    // Redirect coinciding with the accepted request at 0x40.
    lat_min = 1; lat_max = 1; req_fix = 0;
    redir_req = 1; redir_tgt = 32'h0000_0040;
    step(1);
    req_fix = 1; seen40 = 0;
    redir_req = 1; redir_tgt = 32'h0000_0080;
    step(1);
    chk("req_at_40_valid", {31'b0, s_req_v}, 32'd1);
    chk("req_at_40_addr", s_req_a, 32'h0000_0040);
    step(10);
    chk("pc40_never_out", {31'b0, seen40}, 32'd0);
    chk("after40_first_pc", first_pc, 32'h0000_0080);
    drain_check("t4");

    // Random latency, handshakes and redirects.
    lat_min = 1; lat_max = 3;
    req_rand = 1; inst_rand = 1; redir_rand = 1;
    step(800);
    drain_check("t5");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
